// File: rtl/iir_out_buffer.sv
// Output elastic buffer behind filter_iir: captures every sample the filter presents and
// re-presents it through a valid/ready handshake, counting samples dropped on overflow.
module iir_out_buffer #(
   parameter int DW    = 8,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          RST,
   input  logic [DW-1:0] DIN,
   input  logic          VIN,
   output logic [DW-1:0] DOUT,
   output logic          VOUT,
   input  logic          RDY,
   input  logic          CLR_OVF,
   output logic [AW:0]   LEVEL,
   output logic          FULL,
   output logic          EMPTY,
   output logic          OVF,
   output logic [7:0]    DROP_CNT
);

   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wp_q, wp_d;
   logic [AW-1:0] rp_q, rp_d;
   logic [AW:0]   level_q, level_d;
   logic          ovf_q, ovf_d;
   logic [7:0]    drop_cnt_q, drop_cnt_d;

   logic full, empty, pop, push_acc, drop;

   // A full queue still accepts a push when the head leaves on the same edge.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      full       = (level_q == FULL_LEVEL);
      empty      = (level_q == '0);
      pop        = !empty && RDY;
      push_acc   = VIN && (!full || pop);
      drop       = VIN && full && !pop;
      wp_d       = push_acc ? wp_q + AW'(1) : wp_q;
      rp_d       = pop ? rp_q + AW'(1) : rp_q;
      level_d    = level_q + (AW+1)'(push_acc) - (AW+1)'(pop);
      ovf_d      = ovf_q;
      drop_cnt_d = drop_cnt_q;
      if (drop) begin
         ovf_d = 1'b1;
         if (CLR_OVF)
            drop_cnt_d = 8'd1;
         else if (drop_cnt_q != 8'hFF)
            drop_cnt_d = drop_cnt_q + 8'd1;
      end else if (CLR_OVF) begin
         ovf_d      = 1'b0;
         drop_cnt_d = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (RST) begin
         wp_q       <= '0;
         rp_q       <= '0;
         level_q    <= '0;
         ovf_q      <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         level_q    <= level_d;
         ovf_q      <= ovf_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // NOTE: storage has no reset; stale entries are unreachable once the pointers and level clear.
   always_ff @(posedge clk) begin
      if (push_acc)
         mem_q[wp_q] <= DIN;
   end

   assign DOUT     = empty ? '0 : mem_q[rp_q];
   assign VOUT     = !empty;
   assign LEVEL    = level_q;
   assign FULL     = full;
   assign EMPTY    = empty;
   assign OVF      = ovf_q;
   assign DROP_CNT = drop_cnt_q;

endmodule

// File: tb/tb_iir_out_buffer.sv
// Self-checking bench for iir_out_buffer: directed phases plus random traffic, all outputs
// compared every cycle against a queue-based reference model.
module tb_iir_out_buffer;

   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk = 1'b0;
   logic          RST = 1'b0;
   logic [DW-1:0] DIN = '0;
   logic          VIN = 1'b0;
   logic [DW-1:0] DOUT;
   logic          VOUT;
   logic          RDY = 1'b0;
   logic          CLR_OVF = 1'b0;
   logic [AW:0]   LEVEL;
   logic          FULL;
   logic          EMPTY;
   logic          OVF;
   logic [7:0]    DROP_CNT;

   int checks = 0;
   int errors = 0;

   logic [7:0] mq[$];
   bit         m_ovf = 1'b0;
   int         m_cnt = 0;
   logic [7:0] in_seq[$];
   logic [7:0] out_seq[$];
   bit         rec = 1'b0;

   iir_out_buffer #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk      (clk),
      .RST      (RST),
      .DIN      (DIN),
      .VIN      (VIN),
      .DOUT     (DOUT),
      .VOUT     (VOUT),
      .RDY      (RDY),
      .CLR_OVF  (CLR_OVF),
      .LEVEL    (LEVEL),
      .FULL     (FULL),
      .EMPTY    (EMPTY),
      .OVF      (OVF),
      .DROP_CNT (DROP_CNT)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic compare_all(input string ph);
      check({ph, ".level"}, 32'(LEVEL), mq.size());
      check({ph, ".empty"}, 32'(EMPTY), 32'(mq.size() == 0));
      check({ph, ".full"},  32'(FULL),  32'(mq.size() == DEPTH));
      check({ph, ".vout"},  32'(VOUT),  32'(mq.size() != 0));
      check({ph, ".dout"},  32'(DOUT),  (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
      check({ph, ".ovf"},   32'(OVF),   32'(m_ovf));
      check({ph, ".drop"},  32'(DROP_CNT), m_cnt);
   endtask

   // One clock: drive inputs, advance the model, then compare after the edge.
   task automatic step(input string ph, input bit rst, input bit vin, input logic [7:0] din,
                       input bit rdy, input bit clr);
      bit pop, full, acc, drop;
      RST = rst; VIN = vin; DIN = din; RDY = rdy; CLR_OVF = clr;
      if (rst) begin
         mq.delete();
         m_ovf = 1'b0;
         m_cnt = 0;
      end else begin
         pop  = (mq.size() != 0) && rdy;
         full = (mq.size() == DEPTH);
         acc  = vin && (!full || pop);
         drop = vin && full && !pop;
         if (pop) begin
            if (rec) out_seq.push_back(DOUT);
            void'(mq.pop_front());
         end
         if (acc) begin
            mq.push_back(din);
            if (rec) in_seq.push_back(din);
         end
         if (drop) begin
            m_ovf = 1'b1;
            m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
         end else if (clr) begin
            m_ovf = 1'b0;
            m_cnt = 0;
         end
      end
      @(posedge clk);
      #1;
      compare_all(ph);
   endtask

   initial begin
      @(posedge clk);
      #1;

      // Reset then idle
      step("reset", 1, 0, 8'h00, 0, 0);
      step("reset", 1, 0, 8'h00, 0, 0);
      for (int i = 0; i < 5; i++) step("idle", 0, 0, 8'h00, 0, 0);
      check("idle.dout_zero", 32'(DOUT), 32'h0);

      // Passthrough
      step("pass", 0, 1, 8'h11, 1, 0);
      check("pass.first", 32'(DOUT), 32'h11);
      step("pass", 0, 1, 8'h22, 1, 0);
      check("pass.second", 32'(DOUT), 32'h22);
      step("pass", 0, 1, 8'h33, 1, 0);
      check("pass.third", 32'(DOUT), 32'h33);
      check("pass.level", 32'(LEVEL), 32'h1);
      step("pass", 0, 0, 8'h00, 1, 0);

      // Fill and drop
      for (int i = 0; i < 10; i++) begin
         step("fill", 0, 1, 8'(i), 0, 0);
         if (i == 7) check("fill.full_at_8", 32'(FULL), 32'h1);
      end
      check("fill.ovf", 32'(OVF), 32'h1);
      check("fill.drop_cnt", 32'(DROP_CNT), 32'd2);
      for (int i = 0; i < 8; i++) begin
         check("fill.drain_data", 32'(DOUT), i);
         step("drain", 0, 0, 8'h00, 1, 0);
      end
      check("fill.drained_empty", 32'(EMPTY), 32'h1);

      // Full with simultaneous push/pop
      step("clr", 0, 0, 8'h00, 0, 1);
      for (int i = 0; i < 8; i++) step("fill2", 0, 1, 8'(8'h50 + i), 0, 0);
      step("pushpop", 0, 1, 8'hA5, 1, 0);
      check("pushpop.level", 32'(LEVEL), 32'd8);
      check("pushpop.ovf", 32'(OVF), 32'h0);
      check("pushpop.head", 32'(DOUT), 32'h51);
      for (int i = 0; i < 8; i++) begin
         check("pushpop.drain", 32'(DOUT), (i == 7) ? 32'hA5 : 32'(8'h51 + i));
         step("drain2", 0, 0, 8'h00, 1, 0);
      end

      // Wrap-around and stall
      rec = 1'b1;
      for (int i = 0; i < 20; i++)
         step("wrap", 0, 1, 8'($urandom_range(0, 255)), (i % 2) == 0, 0);
      for (int i = 0; i < 24; i++) step("wrapdrain", 0, 0, 8'h00, (i % 2) == 0, 0);
      rec = 1'b0;
      check("wrap.count", out_seq.size(), in_seq.size());
      for (int i = 0; i < in_seq.size() && i < out_seq.size(); i++)
         check("wrap.order", 32'(out_seq[i]), 32'(in_seq[i]));

      // Saturation and clear/drop collision
      for (int i = 0; i < 8; i++) step("fill3", 0, 1, 8'(i), 0, 0);
      for (int i = 0; i < 300; i++) step("sat", 0, 1, 8'hEE, 0, 0);
      check("sat.drop_cnt", 32'(DROP_CNT), 32'd255);
      step("collide", 0, 1, 8'hEE, 0, 1);
      check("collide.ovf", 32'(OVF), 32'h1);
      check("collide.drop_cnt", 32'(DROP_CNT), 32'd1);
      step("middrain", 0, 0, 8'h00, 1, 0);
      step("middrain", 0, 0, 8'h00, 1, 0);
      step("midrst", 1, 1, 8'h77, 1, 0);
      check("midrst.level", 32'(LEVEL), 32'h0);
      check("midrst.vout", 32'(VOUT), 32'h0);

      // Random traffic
      for (int i = 0; i < 600; i++)
         step("rand", ($urandom_range(0, 199) == 0), $urandom_range(0, 3) != 0,
              8'($urandom), $urandom_range(0, 2) != 0, ($urandom_range(0, 29) == 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
